phys_free_list_ctrl: RTL
========================

PHYS_FREE_LIST_CTRL -- requirements
Module: phys_free_list_ctrl

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 128, total physical registers.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural registers (phys 0..ARCH_REGS-1 are mapped at reset).
REQ-003 SHALL have parameter FREE_LIST_SIZE, default PHYS_REGS-ARCH_REGS (96), free-list capacity.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port alloc_req_i  in  8  per-lane request for one new destination register.
REQ-007 SHALL have port alloc_ready_o  out  1  enough free registers for every requested lane.
REQ-008 SHALL have port alloc_phys_o  out  8x7  physical register offered to each lane.
REQ-009 SHALL have port alloc_fire_i  in  1  consumer accepts the offer this cycle.
REQ-010 SHALL have port release_valid_i  in  8  per-lane commit release strobe.
REQ-011 SHALL have port release_phys_i  in  8x7  physical register returned per lane.
REQ-012 SHALL have port free_count_o  out  7  registered number of free entries.
REQ-013 SHALL have port ovf_err_o  out  1  sticky: a release would exceed FREE_LIST_SIZE.
REQ-014 SHALL have port dup_err_o  out  1  sticky: double-free detected (see Configuration).

Function
REQ-015 SHALL store free registers in a circular buffer of FREE_LIST_SIZE 7-bit entries with head, tail and count registers; head and tail wrap modulo FREE_LIST_SIZE (95 -> 0, not power-of-two).
REQ-016 SHALL drive alloc_phys_o[k] combinationally as entry[(head + popcount(alloc_req_i[k-1:0])) mod FREE_LIST_SIZE] for requesting lanes and 0 for non-requesting lanes (compacted, zero-cycle latency).
REQ-017 SHALL assert alloc_ready_o = (free_count >= popcount(alloc_req_i)); 1 when alloc_req_i == 0.
REQ-018 SHALL allocate all-or-nothing: on alloc_fire_i && alloc_ready_o, head += popcount(alloc_req_i); alloc_fire_i while alloc_ready_o=0 SHALL change no state.
REQ-019 SHALL ignore release lanes with release_phys_i == 0 (x0 mapping never freed).
REQ-020 SHALL write accepted releases at tail in ascending lane order, tail += number accepted.
REQ-021 SHALL gate allocation on the current count only; registers released this cycle are not allocatable until the next cycle.
REQ-022 SHALL update count_next = count - allocated + released in one cycle for simultaneous alloc and release, including head/tail wrap in the same cycle.
REQ-023 SHALL, if count - allocated + releases would exceed FREE_LIST_SIZE, drop all releases that cycle, still perform a legal allocation, and set ovf_err_o.
REQ-024 SHALL hold ovf_err_o and dup_err_o set until reset.

Reset
REQ-025 SHALL on rst_n low asynchronously set entry[j] = ARCH_REGS+j, head=0, tail=0, count=FREE_LIST_SIZE, ovf_err_o=0, dup_err_o=0.
REQ-026 SHALL therefore present free_count_o=96, alloc_ready_o=1, alloc_phys_o[0]=32 with alloc_req_i=1 immediately after reset.
REQ-027 SHALL abandon any in-flight allocation or release on reset assertion mid-cycle; no partial update survives.

Configuration
REQ-028 SHALL support macro FREE_LIST_DUPCHK_EN.
REQ-029 SHALL, with FREE_LIST_DUPCHK_EN defined, keep a PHYS_REGS-bit free bitmap (reset: bits ARCH_REGS..PHYS_REGS-1 set); allocation clears bits; a release of a register whose bit is set, or released twice in one cycle, is dropped for that lane and sets dup_err_o.
REQ-030 SHALL, without FREE_LIST_DUPCHK_EN, omit the bitmap, accept all nonzero releases, and tie dup_err_o to 0.

Verification
REQ-031 SHALL cover: reset, alloc_req_i=8'hFF + fire -> alloc_phys_o = 32..39, next cycle free_count_o=88.
REQ-032 SHALL cover: alloc_req_i=8'b1010_0101 + fire -> lanes 0,2,5,7 get 32,33,34,35, others 0; free_count_o=92.
REQ-033 SHALL cover: drain to free_count_o=3, alloc_req_i=4'hF -> alloc_ready_o=0, fire ignored, count stays 3; same cycle release of phys 40 -> count 4 next cycle.
REQ-034 SHALL cover: 12 full-width alloc/release cycles crossing index 95 -> head/tail wrap to 0, offered registers match released order.
REQ-035 SHALL cover: at count 96, release phys 50 -> release dropped, ovf_err_o=1, count stays 96.
REQ-036 SHALL cover (DUPCHK build): release phys 50 twice in lanes 0 and 1 after allocating it -> one accepted, dup_err_o=1; release phys 0 -> ignored, no error.

Source files
------------

// File: rtl/phys_free_list_ctrl.sv
// Physical register free list: circular buffer with 8-lane compacted allocate and release.
// Optional double-free detection bitmap is enabled by defining FREE_LIST_DUPCHK_EN.
module phys_free_list_ctrl #(
    parameter int PHYS_REGS      = 128,
    parameter int ARCH_REGS      = 32,
    parameter int FREE_LIST_SIZE = PHYS_REGS - ARCH_REGS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      alloc_req_i,
    output logic            alloc_ready_o,
    output logic [7:0][6:0] alloc_phys_o,
    input  logic            alloc_fire_i,
    input  logic [7:0]      release_valid_i,
    input  logic [7:0][6:0] release_phys_i,
    output logic [6:0]      free_count_o,
    output logic            ovf_err_o,
    output logic            dup_err_o
);

    localparam logic [7:0] FLS8 = 8'(FREE_LIST_SIZE);

    // Index wrap for a non-power-of-two ring; sum never exceeds 2*size.
    function automatic logic [6:0] wrap_idx(input logic [7:0] sum);
        logic [7:0] v;
        if (sum >= FLS8) begin
            v = sum - FLS8;
        end else begin
            v = sum;
        end
        return v[6:0];
    endfunction

    logic [6:0] r_entry [FREE_LIST_SIZE];
    logic [6:0] r_head;
    logic [6:0] r_tail;
    logic [6:0] r_count;
    logic       r_ovf_err;

    logic [3:0]      w_pre [8];
    logic [3:0]      w_alloc_n;
    logic [7:0][6:0] w_alloc_phys;
    logic            w_ready;
    logic            w_do_alloc;
    logic [3:0]      w_alloc_amt;
    logic [7:0]      w_rel_cand;
    logic [7:0]      w_rel_ok;
    logic [3:0]      w_rel_n;
    logic [6:0]      w_rel_pos [8];
    logic [7:0]      w_cnt_alloc;
    logic [7:0]      w_cnt_raw;
    logic            w_ovf;
    logic [6:0]      w_cnt_next;

    // Prefix popcount of requests gives each lane its compacted slot.
    always_comb begin
        w_alloc_n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            w_pre[k]  = w_alloc_n;
            w_alloc_n = w_alloc_n + {3'd0, alloc_req_i[k]};
        end
    end

    // Zero-latency offer: lane k reads the slot after all earlier requesting lanes.
    always_comb begin
        w_alloc_phys = '0;
        for (int k = 0; k < 8; k++) begin
            if (alloc_req_i[k]) begin
                w_alloc_phys[k] = r_entry[wrap_idx({1'b0, r_head} + {4'd0, w_pre[k]})];
            end else begin
                w_alloc_phys[k] = 7'd0;
            end
        end
    end

    assign w_ready     = ({1'b0, r_count} >= {4'd0, w_alloc_n});
    assign w_do_alloc  = alloc_fire_i & w_ready;
    assign w_alloc_amt = w_do_alloc ? w_alloc_n : 4'd0;

    // Phys 0 is the hardwired zero mapping and is never returned to the pool.
    always_comb begin
        w_rel_cand = '0;
        for (int k = 0; k < 8; k++) begin
            w_rel_cand[k] = release_valid_i[k] & (release_phys_i[k] != 7'd0);
        end
    end

`ifdef FREE_LIST_DUPCHK_EN
    logic [PHYS_REGS-1:0] r_free_map;
    logic                 r_dup_err;
    logic [7:0]           w_dup_lane;
    logic                 w_dup_hit;

    // A lane is a double-free if the register is already free or an earlier lane returns it too.
    always_comb begin
        w_dup_lane = '0;
        for (int k = 0; k < 8; k++) begin
            w_dup_lane[k] = r_free_map[release_phys_i[k]];
            for (int j = 0; j < k; j++) begin
                w_dup_lane[k] = w_dup_lane[k] |
                                (w_rel_cand[j] & (release_phys_i[j] == release_phys_i[k]));
            end
            w_dup_lane[k] = w_dup_lane[k] & w_rel_cand[k];
        end
        w_dup_hit = |w_dup_lane;
    end

    assign w_rel_ok = w_rel_cand & ~w_dup_lane;

    // Bitmap tracks free registers; allocation clears, accepted release sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < PHYS_REGS; j++) begin
                r_free_map[j] <= (j >= ARCH_REGS);
            end
            r_dup_err <= 1'b0;
        end else begin
            if (w_do_alloc) begin
                for (int k = 0; k < 8; k++) begin
                    if (alloc_req_i[k]) begin
                        r_free_map[w_alloc_phys[k]] <= 1'b0;
                    end
                end
            end
            if (!w_ovf) begin
                for (int k = 0; k < 8; k++) begin
                    if (w_rel_ok[k]) begin
                        r_free_map[release_phys_i[k]] <= 1'b1;
                    end
                end
            end
            if (w_dup_hit) begin
                r_dup_err <= 1'b1;
            end
        end
    end

    assign dup_err_o = r_dup_err;
`else
    assign w_rel_ok  = w_rel_cand;
    assign dup_err_o = 1'b0;
`endif

    // Accepted releases pack at tail in ascending lane order.
    always_comb begin
        w_rel_n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            w_rel_pos[k] = wrap_idx({1'b0, r_tail} + {4'd0, w_rel_n});
            w_rel_n      = w_rel_n + {3'd0, w_rel_ok[k]};
        end
    end

    // Overflow drops every release of the cycle but keeps the allocation.
    always_comb begin
        w_cnt_alloc = {1'b0, r_count} - {4'd0, w_alloc_amt};
        w_cnt_raw   = w_cnt_alloc + {4'd0, w_rel_n};
        w_ovf       = (w_cnt_raw > FLS8);
        if (w_ovf) begin
            w_cnt_next = w_cnt_alloc[6:0];
        end else begin
            w_cnt_next = w_cnt_raw[6:0];
        end
    end

    // Ring state: entries, pointers, count and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FREE_LIST_SIZE; j++) begin
                r_entry[j] <= 7'(ARCH_REGS + j);
            end
            r_head    <= 7'd0;
            r_tail    <= 7'd0;
            r_count   <= 7'(FREE_LIST_SIZE);
            r_ovf_err <= 1'b0;
        end else begin
            if (w_do_alloc) begin
                r_head <= wrap_idx({1'b0, r_head} + {4'd0, w_alloc_n});
            end
            if (!w_ovf) begin
                r_tail <= wrap_idx({1'b0, r_tail} + {4'd0, w_rel_n});
                for (int k = 0; k < 8; k++) begin
                    if (w_rel_ok[k]) begin
                        r_entry[w_rel_pos[k]] <= release_phys_i[k];
                    end
                end
            end else begin
                r_ovf_err <= 1'b1;
            end
            r_count <= w_cnt_next;
        end
    end

    assign alloc_ready_o = w_ready;
    assign alloc_phys_o  = w_alloc_phys;
    assign free_count_o  = r_count;
    assign ovf_err_o     = r_ovf_err;

endmodule
